rnn_h_argmax: RTL

RNN_H_ARGMAX -- requirements
Module: rnn_h_argmax

---
 rtl/rnn_h_argmax.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rnn_h_argmax.sv
// rnn_h_argmax: watches the RNN core's hidden-state write bank, tracks the
// running maximum over each 64-entry hidden vector and queues
// {timestep, argmax index, max value} results in a small FIFO.
module rnn_h_argmax #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mce,
    input  logic [2:0]  msel,
    input  logic [16:0] maddr,
    input  logic [19:0] mdata_w,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [10:0] o_step,
    output logic [5:0]  o_idx,
    output logic [19:0] o_max,
    output logic        ovf,
    output logic        seq_err
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 11 + 6 + 20;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [2:0]       HID_BANK  = 3'b101;
    localparam logic [5:0]       LAST_IDX  = 6'd63;

    // S_RUN: accumulating (or waiting for index 0 after reset / a result).
    // S_SKIP: an out-of-order index was seen; ignore captures until index 0.
    typedef enum logic {
        S_RUN  = 1'b0,
        S_SKIP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [5:0]         r_exp;
    logic [5:0]         w_exp_nxt;
    logic [19:0]        r_max;
    logic [19:0]        w_max_nxt;
    logic [5:0]         r_idx;
    logic [5:0]         w_idx_nxt;
    logic [10:0]        r_step;
    logic [10:0]        w_step_nxt;

    logic               w_cap;
    logic [5:0]         w_k;
    logic [10:0]        w_ts;
    logic               w_gt;
    logic               w_push;
    logic               w_seq_set;
    logic [ENTRY_W-1:0] w_push_entry;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_acc;
    logic               w_drop;
    logic               r_ovf;
    logic               r_seq_err;

    // Capture decode; a cycle with reset high never counts as a capture.
    always_comb begin
        w_cap = mce && (msel == HID_BANK) && !reset;
        w_k   = maddr[5:0];
        w_ts  = maddr[16:6];
        w_gt  = $signed(mdata_w) > $signed(r_max);
    end

    // Sequencing state register and running argmax registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_exp   <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_exp   <= w_exp_nxt;
            r_max   <= w_max_nxt;
            r_idx   <= w_idx_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Next-state / running-max update; index 0 always restarts a vector,
    // and the index-63 comparison is folded into the pushed result.
    always_comb begin
        w_state_nxt  = r_state;
        w_exp_nxt    = r_exp;
        w_max_nxt    = r_max;
        w_idx_nxt    = r_idx;
        w_step_nxt   = r_step;
        w_push       = 1'b0;
        w_seq_set    = 1'b0;
        if (w_cap) begin
            if (w_k == 6'd0) begin
                w_max_nxt   = mdata_w;
                w_idx_nxt   = 6'd0;
                w_step_nxt  = w_ts;
                w_exp_nxt   = 6'd1;
                w_state_nxt = S_RUN;
            end else if (r_state == S_RUN) begin
                if (w_k == r_exp) begin
                    if (w_gt) begin
                        w_max_nxt = mdata_w;
                        w_idx_nxt = w_k;
                    end
                    w_exp_nxt = r_exp + 6'd1;
                    if (w_k == LAST_IDX) begin
                        w_push = 1'b1;
                    end
                end else begin
                    w_seq_set   = 1'b1;
                    w_state_nxt = S_SKIP;
                end
            end
        end
        w_push_entry = {r_step, w_idx_nxt, w_max_nxt};
    end

    // FIFO handshake decode: a pop needs a non-empty FIFO, and a full FIFO
    // only accepts a push when the head leaves in the same cycle.
    always_comb begin
        w_full     = (r_count == FULL_CNT);
        w_empty    = (r_count == '0);
        w_pop      = !w_empty && o_ready;
        w_push_acc = w_push && (!w_full || w_pop);
        w_drop     = w_push && w_full && !w_pop;
    end

    // FIFO storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf     <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_seq_set) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    // Output head of FIFO; data forced to zero while nothing is queued.
    always_comb begin
        o_valid = !w_empty;
        ovf     = r_ovf;
        seq_err = r_seq_err;
        if (!w_empty) begin
            {o_step, o_idx, o_max} = r_mem[r_rd_ptr];
        end else begin
            o_step = '0;
            o_idx  = '0;
            o_max  = '0;
        end
    end

endmodule
